// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit with a 1-cycle multiplier and a 32-cycle restoring divider.
// Requests are handshaked in IDLE, and results are held in DONE until they are consumed.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_e;
   state_e            state_q;
   logic [1:0]        op_q;
   logic [XLEN-1:0]   a_q, b_q, rem_q, quo_q, result_q;
   logic [5:0]        cnt_q;
   logic              out_valid_q;
   logic              a_sx, b_sx, div_s, q_neg, r_neg, div_zero, div_ovf;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mul_res, b_mag, a_mag, rem_d, quo_d, fix_res;
   logic [XLEN:0]     trial, diff;
   assign in_ready  = state_q == IDLE;
   assign busy      = state_q != IDLE;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign a_sx      = op_q != 2'd3;
   assign b_sx      = !op_q[1];
   assign prod      = {{XLEN{a_sx & a_q[XLEN-1]}}, a_q} * {{XLEN{b_sx & b_q[XLEN-1]}}, b_q};
   assign mul_res   = (op_q == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   // Divider works on magnitudes; signs are reapplied in FIX
   assign div_s     = !op_q[0];
   assign b_mag     = (div_s && b_q[XLEN-1]) ? -b_q : b_q;
   assign a_mag     = (!op[0] && a[XLEN-1]) ? -a : a;
   assign trial     = {rem_q, quo_q[XLEN-1]};
   assign diff      = trial - {1'b0, b_mag};
   assign rem_d     = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
   assign quo_d     = {quo_q[XLEN-2:0], !diff[XLEN]};
   assign q_neg     = div_s & (a_q[XLEN-1] ^ b_q[XLEN-1]);
   assign r_neg     = div_s & a_q[XLEN-1];
   assign fix_res   = op_q[1] ? (r_neg ? -rem_q : rem_q) : (q_neg ? -quo_q : quo_q);
   assign div_zero  = b == '0;
   assign div_ovf   = !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               op_q  <= op[1:0];
               a_q   <= a;
               b_q   <= b;
               rem_q <= '0;
               quo_q <= a_mag;
               cnt_q <= '0;
               if (!op[2]) begin
                  state_q <= MUL;
               end else if (div_zero) begin
                  result_q    <= op[1] ? a : '1;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else if (div_ovf) begin
                  result_q    <= op[1] ? '0 : a;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  state_q <= DIV;
               end
            end
            MUL: begin
               result_q    <= mul_res;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DIV: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q + 6'd1;
               if (cnt_q == 6'd31) state_q <= FIX;
            end
            FIX: begin
               result_q    <= fix_res;
               out_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven and scoreboarded check of muldiv_unit results, latencies and control corners.
module tb_muldiv_unit;
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;
   logic        clk = 0, rst_n = 1, in_valid = 0, flush = 0, out_ready = 1;
   logic [2:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        in_ready, out_valid, busy;
   logic [31:0] result;
   int          checks = 0, errors = 0;
   logic [31:0] sb_q[$];
   vec_t        tbl[12];
   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx = $signed(x), sy = $signed(y), zy = longint'({32'b0, y});
      longint unsigned ux = {32'b0, x}, uy = {32'b0, y}, up;
      longint p;
      int xi = x, yi = y;
      logic ovf = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
      case (o)
         3'd0: return x * y;
         3'd1: begin p = sx * sy; return p[63:32]; end
         3'd2: begin p = sx * zy; return p[63:32]; end
         3'd3: begin up = ux * uy; return up[63:32]; end
         3'd4: return (y == 0) ? 32'hFFFFFFFF : ovf ? x : 32'(xi / yi);
         3'd5: return (y == 0) ? 32'hFFFFFFFF : x / y;
         3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'(xi % yi);
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction
   function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      if (!o[2]) return 2;
      if (y == 0) return 1;
      if (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
      return 34;
   endfunction
   task automatic start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e, input bit push);
      int k = 0;
      while (!in_ready && k < 200) begin @(negedge clk); k++; end
      @(negedge clk);
      op = o; a = x; b = y; in_valid = 1;
      if (push) sb_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 0;
      a = $urandom; b = $urandom; op = 3'($urandom);
   endtask
   task automatic wait_out(output int n);
      n = 1;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
   endtask
   task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] e, input int lat, input string name);
      int n;
      logic [31:0] exp_r;
      start(o, x, y, e, 1);
      wait_out(n);
      exp_r = sb_q.pop_front();
      chk({name, " result"}, result, exp_r);
      chk({name, " latency"}, 32'(n), 32'(lat));
      @(posedge clk); #1;
   endtask
   initial begin
      int n;
      bit seen;
      logic [2:0] o;
      logic [31:0] x, y, e;
      tbl[0]  = '{3'd0, 32'd6, 32'd5, 32'd30, 2, "MUL 6*5"};
      tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 2, "MULH -1*-1"};
      tbl[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, "MULHU max*max"};
      tbl[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 2, "MULHSU -1*2"};
      tbl[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, "DIV -7/2"};
      tbl[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, "REM -7/2"};
      tbl[6]  = '{3'd5, 32'd100, 32'd7, 32'd14, 34, "DIVU 100/7"};
      tbl[7]  = '{3'd7, 32'd100, 32'd7, 32'd2, 34, "REMU 100/7"};
      tbl[8]  = '{3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "DIVU 5/0"};
      tbl[9]  = '{3'd6, 32'd5, 32'd0, 32'd5, 1, "REM 5/0"};
      tbl[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "DIV ovf"};
      tbl[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "REM ovf"};
      #1 rst_n = 0;
      #2;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
      chk("reset result", result, 32'd0);
      @(negedge clk) rst_n = 1;
      for (int i = 0; i < 12; i++) run(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat, tbl[i].name);
      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(0, 7));
         x = $urandom;
         y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         if (i == 5) begin o = 3'd4; x = 32'h80000000; y = 32'hFFFFFFFF; end
         if (i == 6) begin o = 3'd5; x = 32'h80000000; y = 32'hFFFFFFFF; end
         run(o, x, y, model(o, x, y), model_lat(o, x, y), "random");
      end
      out_ready = 0;
      start(3'd5, 32'd100, 32'd7, 32'd14, 1);
      wait_out(n);
      chk("hold latency", 32'(n), 32'd34);
      e = sb_q.pop_front();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold out_valid", 32'(out_valid), 32'd1);
         chk("hold result", result, e);
         chk("hold in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk) out_ready = 1;
      #1 chk("consume edge in_ready before", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("consumed out_valid", 32'(out_valid), 32'd0);
      chk("consumed in_ready", 32'(in_ready), 32'd1);
      start(3'd5, 32'd100, 32'd7, 32'd0, 0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("pre-flush busy", 32'(busy), 32'd1);
      flush = 1;
      @(posedge clk); #1 flush = 0;
      chk("flush busy", 32'(busy), 32'd0);
      chk("flush in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); seen |= out_valid; end
      chk("flush no out_valid", 32'(seen), 32'd0);
      run(3'd0, 32'd3, 32'd4, 32'd12, 2, "MUL 3*4 after flush");
      @(negedge clk);
      op = 3'd0; a = 32'd1; b = 32'd1; in_valid = 1; flush = 1;
      @(posedge clk); #1 in_valid = 0; flush = 0;
      chk("flush+valid busy", 32'(busy), 32'd0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin @(negedge clk); seen |= out_valid; end
      chk("flush+valid no out_valid", 32'(seen), 32'd0);
      start(3'd4, 32'd1000, 32'd3, 32'd0, 0);
      repeat (5) @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("async reset out_valid", 32'(out_valid), 32'd0);
      chk("async reset busy", 32'(busy), 32'd0);
      chk("async reset in_ready", 32'(in_ready), 32'd1);
      chk("async reset result", result, 32'd0);
      @(negedge clk) rst_n = 1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); seen |= out_valid; end
      chk("post-reset no out_valid", 32'(seen), 32'd0);
      run(3'd0, 32'd2, 32'd3, 32'd6, 2, "MUL 2*3 after reset");
      chk("scoreboard empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
